// File: rtl/probe_unit_pkg.sv
// Shared types and helpers for the L1 probe handler.
// The permission and report encodings match the MetaData/BundleParam definitions.
package probe_unit_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_RESP,
    S_WB_REQ,
    S_WB_WAIT,
    S_ACK,
    S_WRITE
  } fsm_t;

  localparam int MAX_ADDR_W = 64;
  localparam int MAX_WAYS   = 32;

  localparam logic [1:0] CS_NOTHING = 2'd0;
  localparam logic [1:0] CS_BRANCH  = 2'd1;
  localparam logic [1:0] CS_TRUNK   = 2'd2;
  localparam logic [1:0] CS_DIRTY   = 2'd3;

  localparam logic [1:0] CAP_TO_T = 2'd0;
  localparam logic [1:0] CAP_TO_B = 2'd1;
  localparam logic [1:0] CAP_TO_N = 2'd2;

  localparam logic [2:0] RP_TTOB = 3'd0;
  localparam logic [2:0] RP_TTON = 3'd1;
  localparam logic [2:0] RP_BTON = 3'd2;
  localparam logic [2:0] RP_TTOT = 3'd3;
  localparam logic [2:0] RP_BTOB = 3'd4;
  localparam logic [2:0] RP_NTON = 3'd5;

  typedef struct packed {
    logic       dirty;
    logic [2:0] report;
    logic [1:0] next;
  } prob_result_t;

  function automatic logic [MAX_ADDR_W-1:0] block_align(input logic [MAX_ADDR_W-1:0] addr,
                                                         input int unsigned off_w);
    return addr & ~((64'd1 << off_w) - 64'd1);
  endfunction

  function automatic logic [1:0] way_state(input logic [2*MAX_WAYS-1:0] states,
                                           input int unsigned idx);
    return states[2*idx +: 2];
  endfunction

  // Shrink the current permission to the probe cap; an unknown cap shrinks to Nothing.
  function automatic prob_result_t on_prob(input logic [1:0] cur, input logic [1:0] cap);
    prob_result_t r;
    r = '{1'b0, RP_NTON, CS_NOTHING};
    case (cap)
      CAP_TO_T: begin
        case (cur)
          CS_DIRTY:  r = '{1'b1, RP_TTOT, CS_TRUNK};
          CS_TRUNK:  r = '{1'b0, RP_TTOT, CS_TRUNK};
          CS_BRANCH: r = '{1'b0, RP_BTOB, CS_BRANCH};
          default:   r = '{1'b0, RP_NTON, CS_NOTHING};
        endcase
      end
      CAP_TO_B: begin
        case (cur)
          CS_DIRTY:  r = '{1'b1, RP_TTOB, CS_BRANCH};
          CS_TRUNK:  r = '{1'b0, RP_TTOB, CS_BRANCH};
          CS_BRANCH: r = '{1'b0, RP_BTOB, CS_BRANCH};
          default:   r = '{1'b0, RP_NTON, CS_NOTHING};
        endcase
      end
      default: begin
        case (cur)
          CS_DIRTY:  r = '{1'b1, RP_TTON, CS_NOTHING};
          CS_TRUNK:  r = '{1'b0, RP_TTON, CS_NOTHING};
          CS_BRANCH: r = '{1'b0, RP_BTON, CS_NOTHING};
          default:   r = '{1'b0, RP_NTON, CS_NOTHING};
        endcase
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/probe_unit.sv
// TileLink B-channel probe handler: read set metadata, shrink permission, ack or write back, update.
// Optional performance counters are built when PROBE_UNIT_PERF_EN is defined.
module probe_unit
  import probe_unit_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int SET_W  = 6,
  parameter int WAYS   = 4,
  parameter int OFF_W  = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [1:0]        b_param,
  input  logic [ADDR_W-1:0] b_address,
  input  logic              mshr_block,
  output logic              meta_read_valid,
  input  logic              meta_read_ready,
  output logic [SET_W-1:0]  meta_read_idx,
  input  logic [WAYS-1:0]   meta_resp_hit,
  input  logic [2*WAYS-1:0] meta_resp_state,
  output logic              wb_req_valid,
  input  logic              wb_req_ready,
  output logic [2:0]        wb_req_param,
  output logic [ADDR_W-1:0] wb_req_addr,
  output logic [WAYS-1:0]   wb_req_way,
  input  logic              wb_done,
  output logic              c_valid,
  input  logic              c_ready,
  output logic [2:0]        c_param,
  output logic [ADDR_W-1:0] c_address,
  output logic              meta_write_valid,
  input  logic              meta_write_ready,
  output logic [SET_W-1:0]  meta_write_idx,
  output logic [WAYS-1:0]   meta_write_way,
  output logic [1:0]        meta_write_state,
  output logic              busy
`ifdef PROBE_UNIT_PERF_EN
  ,
  output logic [31:0]       perf_probes,
  output logic [31:0]       perf_dirty
`endif
);

  fsm_t              fsm_reg, fsm_next;
  logic [ADDR_W-1:0] addr_reg;
  logic [1:0]        param_reg;
  logic [WAYS-1:0]   way_reg;
  logic [1:0]        meta_state_reg;
  logic [2:0]        report_reg;
  logic              hit_reg;

  logic [WAYS-1:0]   resp_way;
  logic [1:0]        resp_cur;
  logic              resp_hit;
  prob_result_t      prob;

  // Scan from the top so the lowest-index hit wins if several bits are set.
  always_comb begin
    resp_way = '0;
    resp_cur = CS_NOTHING;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (meta_resp_hit[i]) begin
        resp_way    = '0;
        resp_way[i] = 1'b1;
        resp_cur    = way_state(64'(meta_resp_state), i);
      end
    end
  end

  assign resp_hit = |meta_resp_hit;
  assign prob     = on_prob(resp_cur, param_reg);

  always_ff @(posedge clock) begin
    if (reset) begin
      fsm_reg        <= S_IDLE;
      addr_reg       <= '0;
      param_reg      <= '0;
      way_reg        <= '0;
      meta_state_reg <= '0;
      report_reg     <= '0;
      hit_reg        <= 1'b0;
    end else begin
      fsm_reg <= fsm_next;
      if (fsm_reg == S_IDLE && b_valid) begin
        addr_reg  <= ADDR_W'(block_align(64'(b_address), OFF_W));
        param_reg <= b_param;
      end
      if (fsm_reg == S_RESP) begin
        report_reg     <= prob.report;
        meta_state_reg <= prob.next;
        way_reg        <= resp_way;
        hit_reg        <= resp_hit;
      end
    end
  end

  always_comb begin
    fsm_next         = fsm_reg;
    b_ready          = 1'b0;
    meta_read_valid  = 1'b0;
    wb_req_valid     = 1'b0;
    c_valid          = 1'b0;
    meta_write_valid = 1'b0;
    case (fsm_reg)
      S_IDLE: begin
        b_ready = !reset;
        if (b_valid) fsm_next = S_READ;
      end
      S_READ: begin
        meta_read_valid = !mshr_block;
        if (!mshr_block && meta_read_ready) fsm_next = S_RESP;
      end
      S_RESP:    fsm_next = prob.dirty ? S_WB_REQ : S_ACK;
      S_WB_REQ: begin
        wb_req_valid = 1'b1;
        if (wb_req_ready) fsm_next = S_WB_WAIT;
      end
      S_WB_WAIT: if (wb_done) fsm_next = S_WRITE;
      S_ACK: begin
        c_valid = 1'b1;
        if (c_ready) fsm_next = hit_reg ? S_WRITE : S_IDLE;
      end
      S_WRITE: begin
        meta_write_valid = 1'b1;
        if (meta_write_ready) fsm_next = S_IDLE;
      end
      default:   fsm_next = S_IDLE;
    endcase
  end

  assign meta_read_idx    = addr_reg[OFF_W +: SET_W];
  assign meta_write_idx   = addr_reg[OFF_W +: SET_W];
  assign wb_req_param     = report_reg;
  assign wb_req_addr      = addr_reg;
  assign wb_req_way       = way_reg;
  assign c_param          = report_reg;
  assign c_address        = addr_reg;
  assign meta_write_way   = way_reg;
  assign meta_write_state = meta_state_reg;
  assign busy             = (fsm_reg != S_IDLE);

`ifdef PROBE_UNIT_PERF_EN
  logic [31:0] perf_probes_reg, perf_dirty_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_probes_reg <= '0;
      perf_dirty_reg  <= '0;
    end else begin
      if (fsm_reg == S_IDLE && b_valid) perf_probes_reg <= perf_probes_reg + 32'd1;
      if (fsm_reg == S_RESP && prob.dirty) perf_dirty_reg <= perf_dirty_reg + 32'd1;
    end
  end

  assign perf_probes = perf_probes_reg;
  assign perf_dirty  = perf_dirty_reg;
`endif

endmodule

// File: tb/tb_probe_unit.sv
// Directed bench for probe_unit: a permission-table model drives a per-cycle output checker,
// and each directed probe also pins its hand-computed report/state/way values.
module tb_probe_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        b_valid = 1'b0;
  logic        b_ready;
  logic [1:0]  b_param = 2'd0;
  logic [31:0] b_address = 32'd0;
  logic        mshr_block = 1'b0;
  logic        meta_read_valid;
  logic        meta_read_ready = 1'b1;
  logic [5:0]  meta_read_idx;
  logic [3:0]  meta_resp_hit = 4'd0;
  logic [7:0]  meta_resp_state = 8'd0;
  logic        wb_req_valid;
  logic        wb_req_ready = 1'b0;
  logic [2:0]  wb_req_param;
  logic [31:0] wb_req_addr;
  logic [3:0]  wb_req_way;
  logic        wb_done = 1'b0;
  logic        c_valid;
  logic        c_ready = 1'b0;
  logic [2:0]  c_param;
  logic [31:0] c_address;
  logic        meta_write_valid;
  logic        meta_write_ready = 1'b0;
  logic [5:0]  meta_write_idx;
  logic [3:0]  meta_write_way;
  logic [1:0]  meta_write_state;
  logic        busy;

  probe_unit dut (
    .clock(clock), .reset(reset),
    .b_valid(b_valid), .b_ready(b_ready), .b_param(b_param), .b_address(b_address),
    .mshr_block(mshr_block),
    .meta_read_valid(meta_read_valid), .meta_read_ready(meta_read_ready), .meta_read_idx(meta_read_idx),
    .meta_resp_hit(meta_resp_hit), .meta_resp_state(meta_resp_state),
    .wb_req_valid(wb_req_valid), .wb_req_ready(wb_req_ready), .wb_req_param(wb_req_param),
    .wb_req_addr(wb_req_addr), .wb_req_way(wb_req_way), .wb_done(wb_done),
    .c_valid(c_valid), .c_ready(c_ready), .c_param(c_param), .c_address(c_address),
    .meta_write_valid(meta_write_valid), .meta_write_ready(meta_write_ready),
    .meta_write_idx(meta_write_idx), .meta_write_way(meta_write_way),
    .meta_write_state(meta_write_state), .busy(busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int total = 0;
  int passed = 0;
  bit done_flag = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, need 0x%0h", name, act, exp);
  endtask

  task automatic finish_run();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  endtask

  // Encodings: states N/B/T/D = 0..3, caps toT/toB/toN = 0..2,
  // reports TtoB,TtoN,BtoN,TtoT,BtoB,NtoN = 0..5.
  localparam logic [1:0] ST_N = 2'd0, ST_B = 2'd1, ST_T = 2'd2, ST_D = 2'd3;
  localparam logic [2:0] R_TTOB = 3'd0, R_TTON = 3'd1, R_BTON = 3'd2;
  localparam logic [2:0] R_TTOT = 3'd3, R_BTOB = 3'd4, R_NTON = 3'd5;

  logic [31:0] exp_addr = '0;
  logic [5:0]  exp_idx = '0;
  logic        exp_hit = 1'b0;
  logic        exp_dirty = 1'b0;
  logic [2:0]  exp_report = '0;
  logic [1:0]  exp_next = '0;
  logic [3:0]  exp_way = '0;

  // Permission shrink rules as a flat table: {dirty, report, next} per (cap, state).
  function automatic logic [5:0] rule(input logic [1:0] cap, input logic [1:0] st);
    logic [5:0] tbl [3][4];
    tbl[0] = '{{1'b0, R_NTON, ST_N}, {1'b0, R_BTOB, ST_B}, {1'b0, R_TTOT, ST_T}, {1'b1, R_TTOT, ST_T}};
    tbl[1] = '{{1'b0, R_NTON, ST_N}, {1'b0, R_BTOB, ST_B}, {1'b0, R_TTOB, ST_B}, {1'b1, R_TTOB, ST_B}};
    tbl[2] = '{{1'b0, R_NTON, ST_N}, {1'b0, R_BTON, ST_N}, {1'b0, R_TTON, ST_N}, {1'b1, R_TTON, ST_N}};
    return tbl[(cap > 2'd2) ? 2 : int'(cap)][st];
  endfunction

  task automatic model_probe(input logic [1:0] cap, input logic [31:0] addr,
                             input logic [3:0] hitv, input logic [7:0] states);
    logic [1:0] cur;
    logic [5:0] r;
    int w;
    w = -1;
    for (int i = 0; i < 4; i++) if (w < 0 && hitv[i]) w = i;
    exp_addr = {addr[31:6], 6'd0};
    exp_idx  = addr[11:6];
    exp_hit  = (w >= 0);
    exp_way  = exp_hit ? (4'd1 << w) : 4'd0;
    cur      = exp_hit ? ((states >> (2 * w)) & 8'h3) : ST_N;
    r        = rule(cap, cur);
    exp_dirty  = r[5];
    exp_report = r[4:2];
    exp_next   = r[1:0];
  endtask

  // Per-cycle checker: any raised valid must carry exactly what the model predicts.
  always @(negedge clock) begin
    if (!reset) begin
      if (meta_read_valid) begin
        check("read_idx", meta_read_idx, exp_idx);
        check("read_during_mshr", mshr_block, 0);
      end
      if (c_valid) begin
        check("c_valid_vs_model", c_valid, !exp_dirty);
        check("c_param", c_param, exp_report);
        check("c_address", c_address, exp_addr);
      end
      if (wb_req_valid) begin
        check("wb_valid_vs_model", wb_req_valid, exp_dirty);
        check("wb_param", wb_req_param, exp_report);
        check("wb_addr", wb_req_addr, exp_addr);
        check("wb_way", wb_req_way, exp_way);
      end
      if (meta_write_valid) begin
        check("mw_valid_vs_model", meta_write_valid, exp_hit);
        check("mw_idx", meta_write_idx, exp_idx);
        check("mw_way", meta_write_way, exp_way);
        check("mw_state", meta_write_state, exp_next);
      end
    end
  end

  task automatic wait_neg(input string name, ref logic sig);
  endtask

  task automatic run_probe(input logic [1:0] cap, input logic [31:0] addr, input logic [3:0] hitv,
                           input logic [7:0] states, input int mshr_cycles, input int c_stall,
                           input bit reset_in_wb, input logic [2:0] lit_report,
                           input logic [1:0] lit_next, input logic [3:0] lit_way,
                           input logic [31:0] lit_addr);
    int hs;
    int n;
    model_probe(cap, addr, hitv, states);
    mshr_block = (mshr_cycles > 0);
    b_param = cap;
    b_address = addr;
    b_valid = 1'b1;
    @(negedge clock);
    check("b_ready_idle", b_ready, 1);
    hs = cyc;
    @(posedge clock); #1;
    b_valid = 1'b0;
    b_address = 32'hFFFF_FFFF;
    b_param = 2'd0;
    for (int i = 0; i < mshr_cycles; i++) begin
      @(negedge clock);
      check("mshr_stall_read_valid", meta_read_valid, 0);
    end
    if (mshr_cycles > 0) begin
      @(posedge clock); #1;
      mshr_block = 1'b0;
    end
    n = 0;
    do begin @(negedge clock); n++; end while (!meta_read_valid && n < 50);
    check("read_valid_first_cycle", n, 1);
    if (!meta_read_valid) finish_run();
    @(posedge clock); #1;
    meta_resp_hit = hitv;
    meta_resp_state = states;
    @(posedge clock); #1;
    meta_resp_hit = 4'd0;
    meta_resp_state = 8'hAA;
    if (exp_dirty) begin
      n = 0;
      do begin @(negedge clock); n++; end while (!wb_req_valid && n < 50);
      check("wb_req_valid_wait", wb_req_valid, 1);
      if (!wb_req_valid) finish_run();
      check("wb_param_lit", wb_req_param, lit_report);
      check("wb_way_lit", wb_req_way, lit_way);
      check("wb_addr_lit", wb_req_addr, lit_addr);
      check("no_c_on_dirty", c_valid, 0);
      wb_req_ready = 1'b1;
      @(posedge clock); #1;
      wb_req_ready = 1'b0;
      if (reset_in_wb) begin
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check("rst_busy", busy, 0);
        check("rst_b_ready", b_ready, 1);
        check("rst_valids", {meta_read_valid, wb_req_valid, c_valid, meta_write_valid}, 0);
        @(posedge clock); #1;
        wb_done = 1'b1;
        @(posedge clock); #1;
        wb_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
          @(negedge clock);
          check("late_wb_done_busy", busy, 0);
          check("late_wb_done_mw", meta_write_valid, 0);
        end
        @(posedge clock); #1;
        return;
      end
      for (int i = 0; i < 3; i++) begin
        @(negedge clock);
        check("wb_wait_quiet", {c_valid, wb_req_valid, meta_write_valid}, 0);
      end
      @(posedge clock); #1;
      wb_done = 1'b1;
      @(posedge clock); #1;
      wb_done = 1'b0;
    end else begin
      n = 0;
      do begin @(negedge clock); n++; end while (!c_valid && n < 50);
      check("c_valid_wait", c_valid, 1);
      if (!c_valid) finish_run();
      if (mshr_cycles == 0) check("ack_latency", cyc - hs, 3);
      check("c_param_lit", c_param, lit_report);
      check("c_address_lit", c_address, lit_addr);
      for (int i = 0; i < c_stall; i++) begin
        check("c_hold_valid", c_valid, 1);
        check("c_hold_addr", c_address, lit_addr);
        check("c_hold_b_ready", b_ready, 0);
        @(posedge clock); #1;
        @(negedge clock);
      end
      c_ready = 1'b1;
      @(posedge clock); #1;
      c_ready = 1'b0;
      if (!exp_hit) begin
        @(negedge clock);
        check("idle_after_ack", b_ready, 1);
        check("no_mw_on_miss", meta_write_valid, 0);
        @(posedge clock); #1;
        return;
      end
    end
    n = 0;
    do begin @(negedge clock); n++; end while (!meta_write_valid && n < 50);
    check("mw_valid_wait", meta_write_valid, 1);
    if (!meta_write_valid) finish_run();
    check("mw_state_lit", meta_write_state, lit_next);
    check("mw_way_lit", meta_write_way, lit_way);
    meta_write_ready = 1'b1;
    @(posedge clock); #1;
    meta_write_ready = 1'b0;
    @(negedge clock);
    check("idle_after_write", b_ready, 1);
    @(posedge clock); #1;
  endtask

  initial begin
    @(posedge clock); #1;
    @(negedge clock);
    check("reset_b_ready", b_ready, 0);
    check("reset_busy", busy, 0);
    check("reset_valids", {meta_read_valid, wb_req_valid, c_valid, meta_write_valid}, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("post_reset_b_ready", b_ready, 1);
    @(posedge clock); #1;

    // cap, addr, hit, states{w3,w2,w1,w0}, mshr, c_stall, rst, report, next, way, aligned addr
    run_probe(2'd2, 32'h0000_2040, 4'b0100, 8'b01_10_11_00, 0, 0, 0, 3'd1, 2'd0, 4'b0100, 32'h0000_2040);
    run_probe(2'd1, 32'h1234_5FBF, 4'b0001, 8'b00_01_10_11, 0, 0, 0, 3'd0, 2'd1, 4'b0001, 32'h1234_5F80);
    run_probe(2'd0, 32'h0000_0100, 4'b0000, 8'hFF,          0, 0, 0, 3'd5, 2'd0, 4'b0000, 32'h0000_0100);
    run_probe(2'd1, 32'h0000_0FC0, 4'b1000, 8'b01_00_00_00, 10, 0, 0, 3'd4, 2'd1, 4'b1000, 32'h0000_0FC0);
    run_probe(2'd2, 32'h8000_1234, 4'b0010, 8'b00_00_01_00, 0, 5, 0, 3'd2, 2'd0, 4'b0010, 32'h8000_1200);
    run_probe(2'd2, 32'h0000_3000, 4'b0110, 8'b00_00_11_00, 0, 0, 0, 3'd1, 2'd0, 4'b0010, 32'h0000_3000);
    run_probe(2'd0, 32'h0000_0040, 4'b0001, 8'b00_00_00_00, 0, 0, 0, 3'd5, 2'd0, 4'b0001, 32'h0000_0040);
    run_probe(2'd0, 32'h4000_0080, 4'b1000, 8'b11_00_00_00, 0, 0, 1, 3'd3, 2'd2, 4'b1000, 32'h4000_0080);
    run_probe(2'd1, 32'h0000_0A00, 4'b0010, 8'b00_00_10_00, 0, 0, 0, 3'd0, 2'd1, 4'b0010, 32'h0000_0A00);

    done_flag = 1'b1;
    finish_run();
  end

  initial begin
    #200000;
    check("watchdog_done", done_flag, 1);
    finish_run();
  end

endmodule
